// File: rtl/mem_access.sv
// -----------------------------------------------------------------------------
// mem_access -- memory-access stage of the five-stage RISC-V core.
//
// Takes the execute stage's result, store data and memory control, runs one
// request/acknowledge data-memory access per load or store, and hands the
// write-back bundle onward. Byte/halfword/word lanes are steered for stores,
// and load data is sign- or zero-extended. While an access is outstanding the
// upstream registers are held through `stall`.
//
// Ports
//   clk, rst                    clock (rising edge), async active-low reset
//   in_MemRead, in_MemWrite     load / store request (store wins if both set)
//   in_RegWrite, in_RegDest     register write enable / destination
//   in_MemToReg                 write-back selects memory data
//   in_Funct3                   000 B, 001 H, 010 W, 100 BU, 101 HU (011/110/111 = W)
//   in_AluResult                effective address or ALU result
//   in_rs2_value                store data
//   stall                       high for the whole BUSY state
//   dmem_req/we/addr/wdata/wstrb  data-memory request, stable until dmem_ack
//   dmem_ack, dmem_rdata        access complete / read word
//   out_RegWrite, out_RegDest, out_MemToReg, out_AluResult, out_data_out
//                               registered write-back bundle
//   out_misaligned              one-cycle misaligned-access flag
//
// Build option
//   MEM_MISALIGN_TRAP_EN  when defined, a misaligned load/store is not issued;
//                         instead out_misaligned pulses for one cycle with
//                         out_RegWrite = 0 and out_AluResult = faulting address.
//                         When undefined, out_misaligned is tied to 0 and
//                         misaligned accesses are issued as-is.
// -----------------------------------------------------------------------------
module mem_access (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_MemRead,
  input  logic        in_MemWrite,
  input  logic        in_RegWrite,
  input  logic [4:0]  in_RegDest,
  input  logic        in_MemToReg,
  input  logic [2:0]  in_Funct3,
  input  logic [31:0] in_AluResult,
  input  logic [31:0] in_rs2_value,
  output logic        stall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_wstrb,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        out_RegWrite,
  output logic        out_MemToReg,
  output logic [4:0]  out_RegDest,
  output logic [31:0] out_AluResult,
  output logic [31:0] out_data_out,
  output logic        out_misaligned
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t      state_reg, state_next;

  // Instruction captured in IDLE; held unchanged for the whole access.
  logic        c_mem_write_reg, c_mem_write_next;
  logic        c_reg_write_reg, c_reg_write_next;
  logic [4:0]  c_reg_dest_reg,  c_reg_dest_next;
  logic        c_mem_to_reg_reg, c_mem_to_reg_next;
  logic [2:0]  c_funct3_reg,    c_funct3_next;
  logic [31:0] c_addr_reg,      c_addr_next;
  logic [31:0] c_store_reg,     c_store_next;

  // Write-back bundle registers.
  logic        wb_reg_write_reg,  wb_reg_write_next;
  logic        wb_mem_to_reg_reg, wb_mem_to_reg_next;
  logic [4:0]  wb_reg_dest_reg,   wb_reg_dest_next;
  logic [31:0] wb_alu_reg,        wb_alu_next;
  logic [31:0] wb_data_reg,       wb_data_next;

  logic        mem_op_in;
  logic        busy;
  logic [1:0]  off;
  logic        sz_word, sz_half;
  logic [31:0] store_wdata;
  logic [3:0]  store_strb;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] load_ext;

  assign mem_op_in = in_MemRead | in_MemWrite;
  assign busy      = (state_reg == BUSY);
  assign off       = c_addr_reg[1:0];

  // funct3[1] set means a word access (010/011/110/111); 01 in the low bits
  // is a halfword; anything else is a byte.
  assign sz_word = c_funct3_reg[1];
  assign sz_half = (c_funct3_reg[1:0] == 2'b01);

  // Store data is replicated across lanes so the byte enables alone choose
  // which bytes land in memory.
  for (genvar gi = 0; gi < 4; gi++) begin : g_store_lane
    assign store_wdata[gi*8 +: 8] = sz_word ? c_store_reg[gi*8 +: 8] :
                                    sz_half ? c_store_reg[(gi % 2)*8 +: 8] :
                                              c_store_reg[7:0];
  end

  // Halfword lanes follow off[1] only, so an odd halfword address is steered
  // as if it were aligned down.
  always_comb begin
    store_strb = 4'b0001 << off;
    if (sz_word)      store_strb = 4'b1111;
    else if (sz_half) store_strb = 4'b0011 << {off[1], 1'b0};
  end

  // Load extraction and extension.
  assign ld_byte = dmem_rdata[{off, 3'b000} +: 8];
  assign ld_half = off[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];

  always_comb begin
    load_ext = dmem_rdata;
    case (c_funct3_reg)
      3'b000:  load_ext = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  load_ext = {24'h0, ld_byte};
      3'b001:  load_ext = {{16{ld_half[15]}}, ld_half};
      3'b101:  load_ext = {16'h0, ld_half};
      default: load_ext = dmem_rdata;
    endcase
  end

  assign stall      = busy;
  assign dmem_req   = busy;
  assign dmem_we    = busy & c_mem_write_reg;
  assign dmem_wstrb = (busy & c_mem_write_reg) ? store_strb : 4'b0000;
  assign dmem_addr  = {c_addr_reg[31:2], 2'b00};
  assign dmem_wdata = store_wdata;

`ifdef MEM_MISALIGN_TRAP_EN
  logic mis_reg, mis_next;
  logic mis_in;
  // Alignment of the incoming request, judged before it is captured.
  assign mis_in = ((in_Funct3[1:0] == 2'b01) & in_AluResult[0]) |
                  (in_Funct3[1] & (in_AluResult[1:0] != 2'b00));
  assign out_misaligned = mis_reg;
`else
  assign out_misaligned = 1'b0;
`endif

  always_comb begin
    state_next         = state_reg;
    c_mem_write_next   = c_mem_write_reg;
    c_reg_write_next   = c_reg_write_reg;
    c_reg_dest_next    = c_reg_dest_reg;
    c_mem_to_reg_next  = c_mem_to_reg_reg;
    c_funct3_next      = c_funct3_reg;
    c_addr_next        = c_addr_reg;
    c_store_next       = c_store_reg;
    wb_reg_write_next  = wb_reg_write_reg;
    wb_mem_to_reg_next = wb_mem_to_reg_reg;
    wb_reg_dest_next   = wb_reg_dest_reg;
    wb_alu_next        = wb_alu_reg;
    wb_data_next       = wb_data_reg;
`ifdef MEM_MISALIGN_TRAP_EN
    mis_next           = 1'b0;
`endif
    case (state_reg)
      IDLE: begin
        c_mem_write_next  = in_MemWrite;
        c_reg_write_next  = in_RegWrite;
        c_reg_dest_next   = in_RegDest;
        c_mem_to_reg_next = in_MemToReg;
        c_funct3_next     = in_Funct3;
        c_addr_next       = in_AluResult;
        c_store_next      = in_rs2_value;
        if (!mem_op_in) begin
          wb_reg_write_next  = in_RegWrite;
          wb_mem_to_reg_next = in_MemToReg;
          wb_reg_dest_next   = in_RegDest;
          wb_alu_next        = in_AluResult;
          wb_data_next       = 32'h0;
`ifdef MEM_MISALIGN_TRAP_EN
        end else if (mis_in) begin
          // Faulting access: report the address, never touch memory.
          mis_next          = 1'b1;
          wb_reg_write_next = 1'b0;
          wb_alu_next       = in_AluResult;
          wb_data_next      = 32'h0;
`endif
        end else begin
          // Bubble to write-back while the access is in flight.
          wb_reg_write_next = 1'b0;
          state_next        = BUSY;
        end
      end
      BUSY: begin
        if (dmem_ack) begin
          wb_reg_write_next  = c_reg_write_reg;
          wb_mem_to_reg_next = c_mem_to_reg_reg;
          wb_reg_dest_next   = c_reg_dest_reg;
          wb_alu_next        = c_addr_reg;
          wb_data_next       = c_mem_write_reg ? 32'h0 : load_ext;
          state_next         = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg         <= IDLE;
      c_mem_write_reg   <= 1'b0;
      c_reg_write_reg   <= 1'b0;
      c_reg_dest_reg    <= 5'd0;
      c_mem_to_reg_reg  <= 1'b0;
      c_funct3_reg      <= 3'd0;
      c_addr_reg        <= 32'h0;
      c_store_reg       <= 32'h0;
      wb_reg_write_reg  <= 1'b0;
      wb_mem_to_reg_reg <= 1'b0;
      wb_reg_dest_reg   <= 5'd0;
      wb_alu_reg        <= 32'h0;
      wb_data_reg       <= 32'h0;
`ifdef MEM_MISALIGN_TRAP_EN
      mis_reg           <= 1'b0;
`endif
    end else begin
      state_reg         <= state_next;
      c_mem_write_reg   <= c_mem_write_next;
      c_reg_write_reg   <= c_reg_write_next;
      c_reg_dest_reg    <= c_reg_dest_next;
      c_mem_to_reg_reg  <= c_mem_to_reg_next;
      c_funct3_reg      <= c_funct3_next;
      c_addr_reg        <= c_addr_next;
      c_store_reg       <= c_store_next;
      wb_reg_write_reg  <= wb_reg_write_next;
      wb_mem_to_reg_reg <= wb_mem_to_reg_next;
      wb_reg_dest_reg   <= wb_reg_dest_next;
      wb_alu_reg        <= wb_alu_next;
      wb_data_reg       <= wb_data_next;
`ifdef MEM_MISALIGN_TRAP_EN
      mis_reg           <= mis_next;
`endif
    end
  end

  assign out_RegWrite  = wb_reg_write_reg;
  assign out_MemToReg  = wb_mem_to_reg_reg;
  assign out_RegDest   = wb_reg_dest_reg;
  assign out_AluResult = wb_alu_reg;
  assign out_data_out  = wb_data_reg;

endmodule

// File: doc/mem_access.md
# mem_access

Memory-access pipeline stage consuming the execute stage's result, store data and memory control, and producing the write-back bundle. It drives a request/acknowledge data-memory port, performs byte/halfword/word lane steering and load sign/zero extension, and stalls upstream stages while an access is outstanding. It sits between the execute and write-back stages of the five-stage RISC-V core.

## Interface
- No parameters; datapath fixed at 32 bits.
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-low
- in_MemRead, in_MemWrite  in  1 each  load / store request from execute
- in_RegWrite  in  1  instruction writes a register
- in_RegDest  in  5  destination register
- in_MemToReg  in  1  write-back selects memory data
- in_Funct3  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- in_AluResult  in  32  effective address or ALU result
- in_rs2_value  in  32  store data
- stall  out  1  holds IF/ID/EX registers
- dmem_req  out  1  access request, held until ack
- dmem_we  out  1  1 = store
- dmem_addr  out  32  word address, low two bits forced 0
- dmem_wdata  out  32  lane-replicated store data
- dmem_wstrb  out  4  byte enables (stores only; 0 for loads)
- dmem_ack  in  1  access complete; rdata valid for loads
- dmem_rdata  in  32  read word
- out_RegWrite, out_MemToReg  out  1 each  to write-back
- out_RegDest  out  5  to write-back
- out_AluResult  out  32  registered in_AluResult
- out_data_out  out  32  extended load data
- out_misaligned  out  1  one-cycle misaligned-access flag (see Configuration)

## Operation
- States: IDLE, BUSY. Captured registers: control, funct3, address, store data.
- IDLE, rising edge: capture all in_* signals.
  - No memory op: update out_* from the captured values; stay in IDLE.
  - Memory op: go to BUSY; out_RegWrite <= 0, so the write-back sees a bubble.
- BUSY:
  - dmem_req = 1; dmem_* are driven from the captured registers and are stable until the ack.
  - stall = 1 for the whole state, including the ack cycle.
  - On an edge with dmem_ack = 1: update out_* (load: out_data_out = extended rdata; store: out_data_out = 0); go to IDLE.
- Stall: stall = (state == BUSY). In IDLE, stall is 0 and inputs are always accepted.
- Store lanes, with off = addr[1:0]:
  - SB: wstrb = 0001 << off, wdata = {4{rs2[7:0]}}.
  - SH: wstrb = 0011 << off, wdata = {2{rs2[15:0]}}.
  - SW: wstrb = 1111, wdata = rs2.
- Load extraction: select the byte at off, or the halfword at off[1].
  - B/H: sign-extend. BU/HU: zero-extend. W: the full word.
- funct3 011/110/111 are treated as W.
- Misalignment: H/HU with addr[0] = 1; W with addr[1:0] != 0.
- dmem_ack while in IDLE is ignored.
- Simultaneous in_MemRead and in_MemWrite: the store takes precedence.

## Timing
- Reset (async assert): state IDLE; stall, dmem_req, dmem_we, dmem_wstrb, out_RegWrite, out_MemToReg, out_misaligned = 0; all 32-bit and 5-bit outputs = 0.
- Reset asserted mid-BUSY: dmem_req drops immediately, no write-back occurs, the access is abandoned.
- Non-memory op: latency 1 edge, throughput one per cycle.
- Memory op captured at edge N:
  - dmem_req is high from N until the ack edge.
  - With an ack in cycle N+1 (zero wait), out_* update at edge N+1.
  - The next instruction is captured at edge N+2, so each memory op costs at least one bubble.
- dmem_ack held low k cycles: stall is held k+1 cycles, and request signals do not change.

## Configuration
- MEM_MISALIGN_TRAP_EN defined:
  - A misaligned memory op is not issued: no BUSY, no request.
  - out_misaligned = 1 for one cycle with out_RegWrite = 0.
  - out_AluResult carries the faulting address.
- MEM_MISALIGN_TRAP_EN undefined:
  - out_misaligned is tied to 0.
  - Misaligned ops issue normally using the lane rules above; halfword lanes use off[1], so addr[0] is ignored.

## Test plan
- ADD result 0x00000010, rd = 5, no mem op -> next edge: out_RegWrite = 1, out_RegDest = 5, out_AluResult = 0x10, stall never high.
- SB addr 0x103, rs2 = 0x000000A5, zero-wait ack -> dmem_addr = 0x100, wstrb = 1000, wdata = 0xA5A5A5A5; stall high exactly 1 cycle.
- LB addr 0x202, rdata = 0x0080FF00, ack after 3 wait cycles -> stall high 4 cycles; out_data_out = 0xFFFFFF80; LBU at the same address gives 0x00000080.
- LH addr 0x300, rdata = 0x1234F00D -> 0xFFFFF00D; LHU addr 0x302 -> 0x00001234.
- LW addr 0x401 with MEM_MISALIGN_TRAP_EN -> no dmem_req, out_misaligned pulse, out_RegWrite = 0, out_AluResult = 0x401.
- rst low during BUSY with ack pending -> dmem_req = 0 immediately; after release, state IDLE and no write-back.
